// File: rtl/id_stage_pipe.sv
// ============================================================================
// id_stage_pipe
// ----------------------------------------------------------------------------
// Decode stage with an integrated ID/EXE output register. The stage decodes
// the instruction offered by IF, resolves branches combinationally, and
// registers the decoded control/data fields toward EXE. It also inserts
// bubbles on hazards, supports flush, and kills the single instruction that
// follows a taken branch (branch shadow).
//
// Instruction fields: op[31:26], rt[25:21], rs[20:16], rd[15:11], imm[15:0].
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready   handshake toward IF (instruction, pc_in)
//   instruction, pc_in  instruction word and its PC+4
//   src1, src2_rf       combinational register-file read addresses
//   reg1, reg2          register-file read data (same cycle)
//   hazard_detected     stall request: hold input, emit bubble
//   flush               discard output register and current input
//   br_taken, br_target branch resolution (combinational)
//   out_valid/out_ready handshake toward EXE
//   out_*               registered decoded fields
//   dbg_kill            branch-shadow kill flag (state observation)
//
// Optional feature macro: ID_BRANCH_STATS_EN
//   defined   -> adds br_count / br_taken_count (16-bit, saturating)
//   undefined -> counter ports and logic absent
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready does not depend on in_valid; out_valid does not depend
// on out_ready. While out_valid=1 and out_ready=0 every out_* holds stable.
// ============================================================================
module id_stage_pipe #(
   parameter int WORD_LEN     = 32,
   parameter int REG_ADDR_LEN = 5,
   parameter int EXE_CMD_LEN  = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   // IF side
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [WORD_LEN-1:0]     instruction,
   input  logic [WORD_LEN-1:0]     pc_in,
   // register file
   input  logic [WORD_LEN-1:0]     reg1,
   input  logic [WORD_LEN-1:0]     reg2,
   output logic [REG_ADDR_LEN-1:0] src1,
   output logic [REG_ADDR_LEN-1:0] src2_rf,
   // control
   input  logic                    hazard_detected,
   input  logic                    flush,
   output logic                    br_taken,
   output logic [WORD_LEN-1:0]     br_target,
   // EXE side
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [EXE_CMD_LEN-1:0]  out_exe_cmd,
   output logic [WORD_LEN-1:0]     out_val1,
   output logic [WORD_LEN-1:0]     out_val2,
   output logic [WORD_LEN-1:0]     out_st_val,
   output logic [REG_ADDR_LEN-1:0] out_dest,
   output logic [REG_ADDR_LEN-1:0] out_src1,
   output logic [REG_ADDR_LEN-1:0] out_src2,
   output logic                    out_wb_en,
   output logic                    out_mem_r_en,
   output logic                    out_mem_w_en,
   // observation
   output logic                    dbg_kill
`ifdef ID_BRANCH_STATS_EN
   ,
   output logic [15:0]             br_count,
   output logic [15:0]             br_taken_count
`endif
);

   // ------------------------------------------------------------------------
   // Opcodes
   // ------------------------------------------------------------------------
   localparam logic [5:0] OP_NOP  = 6'd0;
   localparam logic [5:0] OP_ADD  = 6'd1;
   localparam logic [5:0] OP_SUB  = 6'd3;
   localparam logic [5:0] OP_AND  = 6'd5;
   localparam logic [5:0] OP_OR   = 6'd6;
   localparam logic [5:0] OP_NOR  = 6'd7;
   localparam logic [5:0] OP_XOR  = 6'd8;
   localparam logic [5:0] OP_SLL  = 6'd10;
   localparam logic [5:0] OP_SRA  = 6'd11;
   localparam logic [5:0] OP_SRL  = 6'd12;
   localparam logic [5:0] OP_ADDI = 6'd32;
   localparam logic [5:0] OP_SUBI = 6'd33;
   localparam logic [5:0] OP_LD   = 6'd36;
   localparam logic [5:0] OP_ST   = 6'd37;
   localparam logic [5:0] OP_BEZ  = 6'd40;
   localparam logic [5:0] OP_BNE  = 6'd41;
   localparam logic [5:0] OP_JMP  = 6'd42;

   // ------------------------------------------------------------------------
   // ALU commands
   // ------------------------------------------------------------------------
   localparam logic [EXE_CMD_LEN-1:0] CMD_ADD = EXE_CMD_LEN'(4'd0);
   localparam logic [EXE_CMD_LEN-1:0] CMD_SUB = EXE_CMD_LEN'(4'd2);
   localparam logic [EXE_CMD_LEN-1:0] CMD_AND = EXE_CMD_LEN'(4'd4);
   localparam logic [EXE_CMD_LEN-1:0] CMD_OR  = EXE_CMD_LEN'(4'd5);
   localparam logic [EXE_CMD_LEN-1:0] CMD_NOR = EXE_CMD_LEN'(4'd6);
   localparam logic [EXE_CMD_LEN-1:0] CMD_XOR = EXE_CMD_LEN'(4'd7);
   localparam logic [EXE_CMD_LEN-1:0] CMD_SHL = EXE_CMD_LEN'(4'd8);
   localparam logic [EXE_CMD_LEN-1:0] CMD_SRA = EXE_CMD_LEN'(4'd9);
   localparam logic [EXE_CMD_LEN-1:0] CMD_SRL = EXE_CMD_LEN'(4'd10);
   localparam logic [EXE_CMD_LEN-1:0] CMD_NOP = EXE_CMD_LEN'(4'hF);

   // ID/EXE register contents
   typedef struct packed {
      logic                    valid;
      logic [EXE_CMD_LEN-1:0]  cmd;
      logic [WORD_LEN-1:0]     val1;
      logic [WORD_LEN-1:0]     val2;
      logic [WORD_LEN-1:0]     st_val;
      logic [REG_ADDR_LEN-1:0] dest;
      logic [REG_ADDR_LEN-1:0] src1;
      logic [REG_ADDR_LEN-1:0] src2;
      logic                    wb_en;
      logic                    mem_r_en;
      logic                    mem_w_en;
   } id_exe_t;

   // ------------------------------------------------------------------------
   // Field extraction
   // ------------------------------------------------------------------------
   logic [5:0]              op;
   logic [REG_ADDR_LEN-1:0] rt;
   logic [REG_ADDR_LEN-1:0] rs;
   logic [REG_ADDR_LEN-1:0] rd;
   logic [15:0]             imm;
   logic [WORD_LEN-1:0]     imm_sext;

   assign op       = instruction[31:26];
   assign rt       = REG_ADDR_LEN'(instruction[25:21]);
   assign rs       = REG_ADDR_LEN'(instruction[20:16]);
   assign rd       = REG_ADDR_LEN'(instruction[15:11]);
   assign imm      = instruction[15:0];
   assign imm_sext = {{(WORD_LEN-16){imm[15]}}, imm};

   // ST reads its store data and BNE its comparand through the second port
   // using rt; every other opcode reads rd there.
   assign src1    = rs;
   assign src2_rf = (op == OP_ST || op == OP_BNE) ? rt : rd;

   assign br_target = pc_in + (imm_sext << 2);

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   id_exe_t out_q, out_d;
   logic    kill_q, kill_d;

   // ------------------------------------------------------------------------
   // Handshake
   // ------------------------------------------------------------------------
   logic out_free;   // output register may take a new value this edge
   logic accept;     // IF transfer completes this edge
   logic take;       // accepted and not discarded by flush
   logic is_branch;
   logic br_cond;

   assign out_free = !out_q.valid || out_ready;
   // Flush consumes the input unconditionally, even over a hazard.
   assign in_ready = flush || (!hazard_detected && out_free);
   assign accept   = in_valid && in_ready;
   assign take     = accept && !flush;

   assign is_branch = (op == OP_BEZ) || (op == OP_BNE) || (op == OP_JMP);

   always_comb begin
      br_cond = 1'b0;
      case (op)
         OP_BEZ:  br_cond = (reg1 == '0);
         OP_BNE:  br_cond = (reg1 != reg2);
         OP_JMP:  br_cond = 1'b1;
         default: br_cond = 1'b0;
      endcase
   end

   // The instruction in the shadow of a taken branch never resolves.
   assign br_taken = take && !kill_q && is_branch && br_cond;

   // ------------------------------------------------------------------------
   // Decode
   // ------------------------------------------------------------------------
   id_exe_t dec;

   always_comb begin
      dec       = '0;
      dec.valid = 1'b1;
      dec.cmd   = CMD_NOP;
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOR,
         OP_XOR, OP_SLL, OP_SRA, OP_SRL: begin
            dec.val1  = reg1;
            dec.val2  = reg2;
            dec.dest  = rd;
            dec.src1  = rs;
            dec.src2  = rd;
            dec.wb_en = 1'b1;
            case (op)
               OP_ADD:  dec.cmd = CMD_ADD;
               OP_SUB:  dec.cmd = CMD_SUB;
               OP_AND:  dec.cmd = CMD_AND;
               OP_OR:   dec.cmd = CMD_OR;
               OP_NOR:  dec.cmd = CMD_NOR;
               OP_XOR:  dec.cmd = CMD_XOR;
               OP_SLL:  dec.cmd = CMD_SHL;
               OP_SRA:  dec.cmd = CMD_SRA;
               default: dec.cmd = CMD_SRL;
            endcase
         end
         OP_ADDI, OP_SUBI, OP_LD, OP_ST: begin
            // Immediate forms leave out_src2 at 0 so forwarding ignores it.
            dec.cmd      = (op == OP_SUBI) ? CMD_SUB : CMD_ADD;
            dec.val1     = reg1;
            dec.val2     = imm_sext;
            dec.src1     = rs;
            dec.dest     = (op == OP_ST) ? '0 : rt;
            dec.wb_en    = (op != OP_ST);
            dec.mem_r_en = (op == OP_LD);
            dec.mem_w_en = (op == OP_ST);
            dec.st_val   = (op == OP_ST) ? reg2 : '0;
         end
         default: begin
            // NOP, branches, jumps and unknown opcodes travel as a valid
            // no-op: enables low, cmd all-ones, data fields zero.
            dec.cmd = CMD_NOP;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Next state
   // ------------------------------------------------------------------------
   always_comb begin
      out_d = out_q;
      if (flush) begin
         out_d = '0;
      end else if (out_free) begin
         // A killed shadow instruction is consumed but loads as a bubble.
         out_d = (take && !kill_q) ? dec : '0;
      end
   end

   // A taken branch arms the kill; the next accepted instruction disarms it
   // (br_taken is low for that instruction because kill_q gates it).
   assign kill_d = flush ? 1'b0 : (take ? br_taken : kill_q);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_q  <= '0;
         kill_q <= 1'b0;
      end else begin
         out_q  <= out_d;
         kill_q <= kill_d;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign out_valid    = out_q.valid;
   assign out_exe_cmd  = out_q.cmd;
   assign out_val1     = out_q.val1;
   assign out_val2     = out_q.val2;
   assign out_st_val   = out_q.st_val;
   assign out_dest     = out_q.dest;
   assign out_src1     = out_q.src1;
   assign out_src2     = out_q.src2;
   assign out_wb_en    = out_q.wb_en;
   assign out_mem_r_en = out_q.mem_r_en;
   assign out_mem_w_en = out_q.mem_w_en;
   assign dbg_kill     = kill_q;

`ifdef ID_BRANCH_STATS_EN
   // ------------------------------------------------------------------------
   // Branch statistics: counts resolved (non-killed, non-flushed) branches.
   // ------------------------------------------------------------------------
   logic [15:0] br_cnt_q, br_cnt_d;
   logic [15:0] br_tk_q, br_tk_d;

   always_comb begin
      br_cnt_d = br_cnt_q;
      br_tk_d  = br_tk_q;
      if (take && !kill_q && is_branch && br_cnt_q != 16'hFFFF) begin
         br_cnt_d = br_cnt_q + 16'd1;
      end
      if (br_taken && br_tk_q != 16'hFFFF) begin
         br_tk_d = br_tk_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         br_cnt_q <= '0;
         br_tk_q  <= '0;
      end else begin
         br_cnt_q <= br_cnt_d;
         br_tk_q  <= br_tk_d;
      end
   end

   assign br_count       = br_cnt_q;
   assign br_taken_count = br_tk_q;
`endif

endmodule
